// File: rtl/caravel_stim_pkg.sv
// Shared types and constants for the Caravel management-side stimulus sequencer.
package caravel_stim_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        START  = 4'd1,
        STAT_A = 4'd2,
        STAT_5 = 4'd3,
        CAP0   = 4'd4,
        SHOW0  = 4'd5,
        CAP1   = 4'd6,
        SHOW1  = 4'd7,
        DONE   = 4'd8
    } state_t;

    localparam logic [15:0] CHK_START  = 16'hAB40;
    localparam logic [15:0] CHK_DONE   = 16'hAB51;
    localparam logic [3:0]  STAT_A_VAL = 4'hA;
    localparam logic [3:0]  STAT_5_VAL = 4'h5;

    localparam int CHK_LSB  = 16;
    localparam int CHK_MSB  = 31;
    localparam int STAT_LSB = 32;
    localparam int STAT_MSB = 35;

    // A zero-length interval is stretched to one cycle.
    function automatic int unsigned min_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/stim_timer.sv
// Loadable down-counter. Loaded with N, o_expired rises on the Nth cycle so the
// owner can transition on that edge; a count of zero means "not yet armed".
module stim_timer #(
    parameter int W = 12
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired,
    output logic         o_empty
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = (r_count == W'(1));
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/caravel_stim_sequencer.sv
// Drives the fixed pass/fail signature onto mprj_io: start word, status toggles,
// two user-data captures GAP cycles apart, then the done word. Optional macro
// STIM_CSB_GATE_EN holds the start until the synchronized csb_in is seen low.
module caravel_stim_sequencer
    import caravel_stim_pkg::*;
#(
    parameter int unsigned START_DELAY = 16,
    parameter int unsigned HOLD        = 8,
    parameter int unsigned GAP         = 1125
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [15:0] user_data_in,
    input  logic        csb_in,
    output logic [37:0] mprj_out,
    output logic [37:0] mprj_oeb,
    output logic        done,
    output logic [3:0]  dbg_state
);

    localparam int unsigned MAX_P = max3(min_one(START_DELAY), min_one(HOLD), min_one(GAP));
    localparam int          TW    = $clog2(MAX_P) + 1;
    // SHOW0 lasts GAP-1 cycles so the CAP1 sampling edge is GAP after CAP0's.
    localparam int unsigned GAP_SHOW = (GAP > 1) ? (GAP - 1) : 1;

    localparam logic [TW-1:0] LD_START = TW'(min_one(START_DELAY));
    localparam logic [TW-1:0] LD_HOLD  = TW'(min_one(HOLD));
    localparam logic [TW-1:0] LD_GAP   = TW'(GAP_SHOW);
    localparam logic [TW-1:0] LD_ONE   = TW'(1);

    state_t          r_state;
    state_t          w_state_nx;
    logic            w_go;
    logic            w_load;
    logic [TW-1:0]   w_load_val;
    logic            w_dec;
    logic            w_expired;
    logic            w_empty;
    logic            w_csb_ok;

    logic [15:0]     r_chk;
    logic [3:0]      r_stat;
    logic            r_drive;
    logic            r_done;
    logic [15:0]     r_mem0;
    logic [15:0]     r_mem1;
    logic [15:0]     w_chk;

`ifdef STIM_CSB_GATE_EN
    logic r_csb_meta;
    logic r_csb_sync;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_csb_meta <= 1'b1;
            r_csb_sync <= 1'b1;
        end else begin
            r_csb_meta <= csb_in;
            r_csb_sync <= r_csb_meta;
        end
    end

    assign w_csb_ok = ~r_csb_sync;
`else
    logic w_unused_csb;
    assign w_unused_csb = csb_in;
    assign w_csb_ok     = 1'b1;
`endif

    stim_timer #(.W(TW)) u_timer (
        .clock      (clock),
        .resetb     (resetb),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_expired  (w_expired),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            IDLE: begin
                // An empty timer in IDLE means the start delay is not armed yet.
                if (w_empty) begin
                    if (w_csb_ok) begin
                        w_load     = 1'b1;
                        w_load_val = LD_START;
                    end
                end else if (w_expired) begin
                    w_state_nx = START;
                    w_load     = 1'b1;
                    w_load_val = LD_HOLD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            START, STAT_A, STAT_5, CAP0, SHOW0, CAP1, SHOW1: begin
                if (w_expired) begin
                    w_load = 1'b1;
                    case (r_state)
                        START:   begin w_state_nx = STAT_A; w_load_val = LD_HOLD; end
                        STAT_A:  begin w_state_nx = STAT_5; w_load_val = LD_HOLD; end
                        STAT_5:  begin w_state_nx = CAP0;   w_load_val = LD_ONE;  end
                        CAP0:    begin w_state_nx = SHOW0;  w_load_val = LD_GAP;  end
                        SHOW0:   begin w_state_nx = CAP1;   w_load_val = LD_ONE;  end
                        CAP1:    begin w_state_nx = SHOW1;  w_load_val = LD_HOLD; end
                        default: begin w_state_nx = DONE;   w_load_val = LD_ONE;  end
                    endcase
                end else begin
                    w_dec = 1'b1;
                end
            end
            DONE: begin
                w_state_nx = DONE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign w_go = (w_state_nx != r_state);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_chk   <= '0;
            r_stat  <= '0;
            r_drive <= 1'b0;
            r_done  <= 1'b0;
            r_mem0  <= '0;
            r_mem1  <= '0;
        end else begin
            if (r_state == CAP0) r_mem0 <= user_data_in;
            if (r_state == CAP1) r_mem1 <= user_data_in;
            if (w_go) begin
                case (w_state_nx)
                    START: begin
                        r_chk   <= CHK_START;
                        r_stat  <= '0;
                        r_drive <= 1'b1;
                    end
                    STAT_A: r_stat <= STAT_A_VAL;
                    STAT_5: r_stat <= STAT_5_VAL;
                    DONE: begin
                        r_chk  <= CHK_DONE;
                        r_stat <= '0;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Captured words are shown straight from the register memory; CAP1 keeps mem[0].
    always_comb begin
        w_chk = r_chk;
        if ((r_state == SHOW0) || (r_state == CAP1)) begin
            w_chk = r_mem0;
        end else if (r_state == SHOW1) begin
            w_chk = r_mem1;
        end
    end

    always_comb begin
        mprj_out                    = '0;
        mprj_out[CHK_MSB:CHK_LSB]   = w_chk;
        mprj_out[STAT_MSB:STAT_LSB] = r_stat;
        mprj_oeb                    = '1;
        mprj_oeb[STAT_MSB:CHK_LSB]  = {(STAT_MSB - CHK_LSB + 1){~r_drive}};
    end

    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_caravel_stim_sequencer.sv
// Directed bench for caravel_stim_sequencer: signature timing, captures, wrap,
// async reset and (with STIM_CSB_GATE_EN) the csb start gate.
module tb_caravel_stim_sequencer;
    import caravel_stim_pkg::*;

`ifdef STIM_CSB_GATE_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic        clock = 1'b0;
    logic        resetb;
    logic [15:0] user_data_in;
    logic        csb_in;
    logic [37:0] mprj_out;
    logic [37:0] mprj_oeb;
    logic        done;
    logic [3:0]  dbg_state;

    int n_checks;
    int n_fail;
    int edge_n;

    logic [37:0] oeb_on;
    logic [37:0] oeb_off;
    logic [37:0] out_done;
    logic [15:0] exp_v;

    caravel_stim_sequencer dut (
        .clock        (clock),
        .resetb       (resetb),
        .user_data_in (user_data_in),
        .csb_in       (csb_in),
        .mprj_out     (mprj_out),
        .mprj_oeb     (mprj_oeb),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counter models the user project: it reads k-1 at the k-th edge after release.
    task automatic step();
        @(posedge clock);
        #2;
        edge_n++;
        user_data_in = user_data_in + 16'd1;
    endtask

    task automatic step_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic release_reset(input logic [15:0] seed);
        resetb       = 1'b1;
        edge_n       = 0;
        user_data_in = seed;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        edge_n       = 0;
        resetb       = 1'b0;
        csb_in       = 1'b0;
        user_data_in = 16'h0000;
        oeb_on       = {2'b11, 20'h00000, 16'hFFFF};
        oeb_off      = 38'h3F_FFFF_FFFF;
        out_done     = {2'b00, 4'h0, 16'hAB51, 16'h0000};

        repeat (10) step();
        check("rst_oeb",   mprj_oeb, oeb_off);
        check("rst_out",   mprj_out, 38'h0);
        check("rst_done",  38'(done), 38'h0);
        check("rst_state", 38'(dbg_state), 38'(IDLE));

        // Run 1: counter from 0.
        release_reset(16'h0000);
        step_to(16 + D);
        check("idle_out", mprj_out, 38'h0);
        check("idle_oeb", mprj_oeb, oeb_off);
        step_to(17 + D);
        check("start_chk",  38'(mprj_out[31:16]), 38'hAB40);
        check("start_stat", 38'(mprj_out[35:32]), 38'h0);
        check("start_oeb",  mprj_oeb, oeb_on);
        step_to(24 + D);
        check("start_end_chk",  38'(mprj_out[31:16]), 38'hAB40);
        check("start_end_stat", 38'(mprj_out[35:32]), 38'h0);
        step_to(25 + D);
        check("stat_a_first", 38'(mprj_out[35:32]), 38'hA);
        check("stat_a_chk",   38'(mprj_out[31:16]), 38'hAB40);
        step_to(32 + D);
        check("stat_a_last", 38'(mprj_out[35:32]), 38'hA);
        step_to(33 + D);
        check("stat_5_first", 38'(mprj_out[35:32]), 38'h5);
        step_to(40 + D);
        check("stat_5_last", 38'(mprj_out[35:32]), 38'h5);
        step_to(41 + D);
        check("cap0_chk", 38'(mprj_out[31:16]), 38'hAB40);
        step_to(42 + D);
        exp_v = 16'h0029 + 16'(D);
        check("show0_v",     38'(mprj_out[31:16]), 38'(exp_v));
        check("show0_state", 38'(dbg_state), 38'(SHOW0));
        step_to(1165 + D);
        check("show0_late", 38'(mprj_out[31:16]), 38'(exp_v));
        step_to(1166 + D);
        check("cap1_chk", 38'(mprj_out[31:16]), 38'(exp_v));
        step_to(1167 + D);
        check("show1_v",    38'(mprj_out[31:16]), 38'(exp_v + 16'h0465));
        check("show1_stat", 38'(mprj_out[35:32]), 38'h5);
        step_to(1174 + D);
        check("show1_last", 38'(mprj_out[31:16]), 38'(exp_v + 16'h0465));
        check("pre_done",   38'(done), 38'h0);
        step_to(1175 + D);
        check("done_out",  mprj_out, out_done);
        check("done_flag", 38'(done), 38'h1);
        check("done_oeb",  mprj_oeb, oeb_on);
        for (int i = 0; i < 1000; i++) begin
            step();
            check("done_hold_out",  mprj_out, out_done);
            check("done_hold_flag", 38'(done), 38'h1);
        end

        // Run 2: counter preloaded so the second capture wraps.
        resetb = 1'b0;
        repeat (10) step();
        release_reset(16'hFF00);
        step_to(42 + D);
        check("wrap_v0", 38'(mprj_out[31:16]), 38'(16'hFF29 + 16'(D)));
        step_to(1167 + D);
        check("wrap_v1", 38'(mprj_out[31:16]), 38'(16'h038E + 16'(D)));

        // Run 3: asynchronous reset in the middle of SHOW0.
        resetb = 1'b0;
        repeat (3) step();
        release_reset(16'h0000);
        step_to(600);
        check("mid_state", 38'(dbg_state), 38'(SHOW0));
        #1;
        resetb = 1'b0;
        #1;
        check("async_out",   mprj_out, 38'h0);
        check("async_oeb",   mprj_oeb, oeb_off);
        check("async_done",  38'(done), 38'h0);
        check("async_state", 38'(dbg_state), 38'(IDLE));
        repeat (2) step();
        release_reset(16'h0000);
        step_to(16 + D);
        check("restart_idle", mprj_out, 38'h0);
        step_to(17 + D);
        check("restart_chk", 38'(mprj_out[31:16]), 38'hAB40);

`ifdef STIM_CSB_GATE_EN
        resetb = 1'b0;
        csb_in = 1'b1;
        repeat (5) step();
        release_reset(16'h0000);
        step_to(500);
        check("gate_hold_out", mprj_out, 38'h0);
        check("gate_hold_oeb", mprj_oeb, oeb_off);
        csb_in = 1'b0;
        edge_n = 0;
        step_to(18);
        check("gate_pre_out", mprj_out, 38'h0);
        step_to(19);
        check("gate_start_chk", 38'(mprj_out[31:16]), 38'hAB40);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/caravel_stim_sequencer.md
Name: caravel_stim_sequencer

Overview:
- Management-side stimulus sequencer that drives the user-project IO bus with a fixed pass/fail signature sequence.
- Announces start with a check word and then toggles a status nibble.
- Captures two samples of a user-project 16-bit value into a two-entry register memory and copies each back onto the check bits, then signals done.
- Sits between the management core clock domain and the 38-bit mprj_io pad bus; an off-chip monitor watches mprj_io[31:16] (checkbits) and mprj_io[35:32] (status).

Parameters:
- START_DELAY, 16, cycles after reset release before the first output word.
- HOLD, 8, cycles each status value and each check word is held before advancing.
- GAP, 1125, cycles between the first and second user-data captures.

Ports:
- clock  input  1  system clock; all state on rising edge.
- resetb  input  1  reset; asynchronous assert, active-low.
- user_data_in  input  16  user-project value to capture (e.g. free-running counter).
- csb_in  input  1  sampled copy of mprj_io[3] (housekeeping SPI CSB).
- mprj_out  output  38  pad output values.
- mprj_oeb  output  38  pad output enables, active-low.
- done  output  1  high once the final signature is driven.

Behaviour:
- Reset (resetb=0, asynchronous): state IDLE, mprj_out=0, mprj_oeb=all 1s, mem[0]=mem[1]=0, timer=0, done=0.
- Bit map:
  - checkbits = mprj_out[31:16]; status = mprj_out[35:32].
  - In every state except IDLE, mprj_oeb[35:16]=0; all other bits of mprj_oeb stay 1.
  - mprj_out bits outside [35:16] are always 0.
- States, with a single down-counting timer reloaded on each transition:
  - IDLE: wait START_DELAY cycles, then go to START.
  - START: checkbits=16'hAB40, status=0; hold HOLD cycles, then go to STAT_A.
  - STAT_A: status=4'hA, checkbits unchanged; hold HOLD cycles, then go to STAT_5.
  - STAT_5: status=4'h5; hold HOLD cycles, then go to CAP0.
  - CAP0 (one cycle): mem[0] <= user_data_in; go to SHOW0.
  - SHOW0: checkbits=mem[0]. Exactly GAP cycles after the CAP0 sampling edge, go to CAP1.
  - CAP1 (one cycle): mem[1] <= user_data_in; go to SHOW1.
  - SHOW1: checkbits=mem[1]; hold HOLD cycles, then go to DONE.
  - DONE: checkbits=16'hAB51, status=0, done=1. Terminal; only reset leaves it.
- Output registers update on the clock edge that enters a state, so a new value is visible one cycle after the transition decision.
- Capture timing: with a user counter incrementing once per cycle, mem[1]-mem[0] == GAP modulo 2^16 (wrap-around allowed, no saturation).
- A reset asserted mid-sequence immediately returns all outputs to reset values; the sequence restarts from IDLE after release.
- Timer width is ceil(log2(max parameter))+1. A parameter value of 0 is treated as 1.

Optional Feature:
- Macro STIM_CSB_GATE_EN.
- Defined: IDLE additionally waits while csb_in==1. START_DELAY begins counting only after csb_in is first seen 0, with csb_in passed through a 2-flop synchronizer. Once the sequence has left IDLE, csb_in is ignored.
- Undefined: csb_in is unused and the sequence starts purely on START_DELAY.

Decomposition:
- Package caravel_stim_pkg holds:
  - state enum (IDLE, START, STAT_A, STAT_5, CAP0, SHOW0, CAP1, SHOW1, DONE);
  - constants CHK_START=16'hAB40, CHK_DONE=16'hAB51, STAT_A_VAL=4'hA, STAT_5_VAL=4'h5;
  - bit-range localparams CHK_LSB=16, CHK_MSB=31, STAT_LSB=32, STAT_MSB=35.
- One natural sub-module, stim_timer: a loadable down-counter with an expired flag.

Test Plan:
- Reset behaviour: hold resetb=0 for 10 cycles -> mprj_oeb=38'h3F_FFFF_FFFF, mprj_out=0, done=0. Assert reset asynchronously mid-SHOW0 -> outputs return to reset values with no clock edge.
- Start signature: release reset, then wait 16+1 cycles -> checkbits=16'hAB40, status=0, mprj_oeb[35:16]=0.
- Status toggle: continue -> status goes to 4'hA, then 4'h5, each value lasting exactly 8 cycles.
- Capture/copy: drive user_data_in as a per-cycle counter starting at 0 on reset release. Required: checkbits shows mem[0]=V, then mem[1]=V+16'h0465. Check V is exact for the default parameters, and check the wrap case when the counter is preloaded to 16'hFF00.
- Completion: final state -> checkbits=16'hAB51, done=1; the values stay stable for 1000 further cycles.
- Gate feature (STIM_CSB_GATE_EN defined): hold csb_in=1 for 500 cycles -> outputs stay in reset state. Drop csb_in to 0 -> AB40 appears 2+16+1 cycles later.
